// File: rtl/fifo_uart_tx_if.sv
// Bundle of the FIFO read-side and UART-side signals for the drain stage.
// The master modport is the UART transmitter; the slave modport is the
// environment that owns the FIFO, the enable control and the pad.
interface fifo_uart_tx_if;
  logic       enable;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic [7:0] bytes_sent;

  modport master (
    input  enable,
    input  fifo_empty,
    input  fifo_data,
    output fifo_rd,
    output tx,
    output busy,
    output bytes_sent
  );

  modport slave (
    output enable,
    output fifo_empty,
    output fifo_data,
    input  fifo_rd,
    input  tx,
    input  busy,
    input  bytes_sent
  );
endinterface

// File: rtl/fifo_uart_tx.sv
// FIFO drain stage: pops one byte at a time from the FIFO read port and
// serializes it as an 8-bit, no-parity UART frame with 1 or 2 stop bits.
// All outputs are registered; they are computed from the next state so
// that each output is valid in the same cycle as the state it belongs to.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input logic            clk,
  input logic            rst_n,
  fifo_uart_tx_if.master bus
);

  // Last value of the baud counter within one bit period.
  localparam logic [15:0] LAST_CNT  = 16'(CLKS_PER_BIT - 1);
  // Index of the final stop bit (0 for one stop bit, 1 for two).
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_POP   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_START = 3'd3,
    ST_DATA  = 3'd4,
    ST_STOP  = 3'd5
  } state_t;

  state_t      state_r;
  state_t      state_s;
  logic [15:0] cnt_r;
  logic [15:0] cnt_s;
  logic [2:0]  bit_idx_r;
  logic [2:0]  bit_idx_s;
  logic        stop_idx_r;
  logic        stop_idx_s;
  logic [7:0]  shift_r;
  logic [7:0]  shift_s;
  logic [7:0]  bytes_sent_r;
  logic [7:0]  bytes_sent_s;
  logic        tx_r;
  logic        tx_s;
  logic        fifo_rd_r;
  logic        fifo_rd_s;
  logic        busy_r;
  logic        busy_s;
  logic        cnt_last_s;
  logic        can_start_s;

  assign cnt_last_s  = (cnt_r == LAST_CNT);
  // A new frame may begin only when permitted and data is waiting.
  assign can_start_s = bus.enable & ~bus.fifo_empty;

  assign bus.tx         = tx_r;
  assign bus.fifo_rd    = fifo_rd_r;
  assign bus.busy       = busy_r;
  assign bus.bytes_sent = bytes_sent_r;

  // State register and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= 16'd0;
      bit_idx_r    <= 3'd0;
      stop_idx_r   <= 1'b0;
      shift_r      <= 8'd0;
      bytes_sent_r <= 8'd0;
      tx_r         <= 1'b1;
      fifo_rd_r    <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      bit_idx_r    <= bit_idx_s;
      stop_idx_r   <= stop_idx_s;
      shift_r      <= shift_s;
      bytes_sent_r <= bytes_sent_s;
      tx_r         <= tx_s;
      fifo_rd_r    <= fifo_rd_s;
      busy_r       <= busy_s;
    end
  end

  // Next-state, baud/bit counters, shift register and frame counter.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r + 16'd1;
    bit_idx_s    = bit_idx_r;
    stop_idx_s   = stop_idx_r;
    shift_s      = shift_r;
    bytes_sent_s = bytes_sent_r;

    case (state_r)
      ST_IDLE: begin
        cnt_s = 16'd0;
        if (can_start_s) begin
          state_s = ST_POP;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_POP: begin
        cnt_s   = 16'd0;
        state_s = ST_LOAD;
      end

      ST_LOAD: begin
        // FIFO read data is valid now, one cycle after the pop strobe.
        cnt_s      = 16'd0;
        shift_s    = bus.fifo_data;
        bit_idx_s  = 3'd0;
        stop_idx_s = 1'b0;
        state_s    = ST_START;
      end

      ST_START: begin
        if (cnt_last_s) begin
          cnt_s   = 16'd0;
          state_s = ST_DATA;
        end else begin
          state_s = ST_START;
        end
      end

      ST_DATA: begin
        if (cnt_last_s) begin
          cnt_s     = 16'd0;
          shift_s   = {1'b0, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 3'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          state_s = ST_DATA;
        end
      end

      ST_STOP: begin
        if (cnt_last_s) begin
          cnt_s = 16'd0;
          if (stop_idx_r == LAST_STOP) begin
            // End of the frame: count it and decide whether to chain.
            stop_idx_s   = 1'b0;
            bytes_sent_s = bytes_sent_r + 8'd1;
            if (can_start_s) begin
              state_s = ST_POP;
            end else begin
              state_s = ST_IDLE;
            end
          end else begin
            stop_idx_s = stop_idx_r + 1'b1;
            state_s    = ST_STOP;
          end
        end else begin
          state_s = ST_STOP;
        end
      end

      default: begin
        cnt_s   = 16'd0;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered outputs line up with it.
  always_comb begin
    tx_s      = 1'b1;
    fifo_rd_s = 1'b0;
    busy_s    = 1'b1;

    case (state_s)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_POP: begin
        fifo_rd_s = 1'b1;
      end
      ST_START: begin
        tx_s = 1'b0;
      end
      ST_DATA: begin
        tx_s = shift_s[0];
      end
      default: begin
        tx_s = 1'b1;
      end
    endcase
  end

endmodule
